// File: rtl/hub75_scan_reader.sv
// HUB75 scan engine: reads RGB565 pairs from the frame buffer, shifts one bit-plane per pass
// and displays it with binary-coded modulation (plane p is lit for BASE_TIME<<p cycles).
module hub75_scan_reader #(
  parameter int COLUMNS   = 64,
  parameter int ROW_PAIRS = 16,
  parameter int PLANES    = 5,
  parameter int BASE_TIME = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  output logic [10:0]                  address_b_o,
  output logic                         clock_en_b_o,
  input  logic [15:0]                  qb_i,
  output logic                         panel_clk_o,
  output logic                         panel_latch_o,
  output logic                         panel_oe_o,
  output logic [$clog2(ROW_PAIRS)-1:0] panel_row_addr_o,
  output logic [2:0]                   rgb1_o,
  output logic [2:0]                   rgb2_o,
  output logic                         frame_start_o
);

  localparam int CW = $clog2(COLUMNS);
  localparam int RW = $clog2(ROW_PAIRS);
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int TW = $clog2((BASE_TIME << (PLANES - 1)) + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_BLANK   = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_DISPLAY = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [10:0]   address_q, address_d;
  logic          cen_q, cen_d, pclk_q, pclk_d, latch_q, latch_d, oe_q, oe_d, fs_q, fs_d;
  logic [RW-1:0] row_addr_q;
  logic [15:0]   top_q;
  logic [2:0]    rgb1_q, rgb2_q;
  logic [2:0]    bit_k;
  logic          live_rgb;

  // Highest PLANES bits of each channel are displayed; plane 0 is the least significant of them.
  assign bit_k = 3'(5 - PLANES) + 3'(plane_q);

  function automatic logic [2:0] plane_bits(input logic [15:0] w, input logic [2:0] k);
    logic [3:0] kk;
    kk = {1'b0, k};
    return {w[kk + 4'd11], w[kk + 4'd6], w[kk]};
  endfunction

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    col_d   = col_q;
    row_d   = row_q;
    plane_d = plane_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_SHIFT;
          phase_d = '0;
          col_d   = '0;
          row_d   = '0;
          plane_d = '0;
        end
      end
      S_SHIFT: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (col_q == CW'(COLUMNS - 1)) begin
            state_d = S_BLANK;
            col_d   = '0;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_BLANK: state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_DISPLAY;
        timer_d = TW'(BASE_TIME << plane_q) - TW'(1);
      end
      S_DISPLAY: begin
        if (timer_q == '0) begin
          if (plane_q == PW'(PLANES - 1)) begin
            plane_d = '0;
            row_d   = row_q + RW'(1);
          end else begin
            plane_d = plane_q + PW'(1);
          end
          state_d = enable_i ? S_SHIFT : S_IDLE;
          phase_d = '0;
          col_d   = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Panel and buffer controls are registered from the next state so they line up with it.
  always_comb begin
    cen_d     = (state_d == S_SHIFT) && !phase_d[1];
    address_d = cen_d ? {phase_d[0], row_d, col_d} : address_q;
    pclk_d    = (state_d == S_SHIFT) && (phase_d == 2'd3);
    latch_d   = (state_d == S_LATCH);
    oe_d      = (state_d != S_DISPLAY);
    fs_d      = (state_d == S_SHIFT) && (phase_d == 2'd0) && (col_d == '0) &&
                (row_d == '0) && (plane_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      timer_q    <= '0;
      address_q  <= '0;
      cen_q      <= 1'b0;
      pclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      oe_q       <= 1'b1;
      fs_q       <= 1'b0;
      row_addr_q <= '0;
      top_q      <= '0;
      rgb1_q     <= '0;
      rgb2_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      col_q     <= col_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      timer_q   <= timer_d;
      address_q <= address_d;
      cen_q     <= cen_d;
      pclk_q    <= pclk_d;
      latch_q   <= latch_d;
      oe_q      <= oe_d;
      fs_q      <= fs_d;
      if (state_d == S_LATCH) row_addr_q <= row_q;
      if (state_q == S_SHIFT && phase_q == 2'd1) top_q <= qb_i;
      if (state_q == S_SHIFT && phase_q == 2'd2) begin
        rgb1_q <= plane_bits(top_q, bit_k);
        rgb2_q <= plane_bits(qb_i, bit_k);
      end
    end
  end

  // Bottom word arrives in ph2; presenting it straight away gives a full cycle of setup before PanelClk rises.
  assign live_rgb         = (state_q == S_SHIFT) && (phase_q == 2'd2);
  assign rgb1_o           = live_rgb ? plane_bits(top_q, bit_k) : rgb1_q;
  assign rgb2_o           = live_rgb ? plane_bits(qb_i, bit_k) : rgb2_q;
  assign address_b_o      = address_q;
  assign clock_en_b_o     = cen_q;
  assign panel_clk_o      = pclk_q;
  assign panel_latch_o    = latch_q;
  assign panel_oe_o       = oe_q;
  assign panel_row_addr_o = row_addr_q;
  assign frame_start_o    = fs_q;

endmodule

// File: tb/tb_hub75_scan_reader.sv
// Scoreboard bench for hub75_scan_reader: a pass-level model queues expected reads, pixels,
// latched rows and lit durations; a negedge monitor compares them as the DUT produces them.
module tb_hub75_scan_reader;

  localparam int COLUMNS   = 64;
  localparam int ROW_PAIRS = 16;
  localparam int PLANES    = 5;
  localparam int BASE_TIME = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] addr;
  logic        cen;
  logic [15:0] qb = '0;
  logic        pclk, latch, oe, fs;
  logic [3:0]  row_addr;
  logic [2:0]  rgb1, rgb2;

  logic [15:0] mem [2048];

  int checks = 0;
  int errors = 0;
  int fs_count = 0;

  logic [10:0] exp_addr [$];
  logic [5:0]  exp_pix [$];
  logic [3:0]  exp_row [$];
  int          exp_run [$];

  hub75_scan_reader #(
    .COLUMNS(COLUMNS), .ROW_PAIRS(ROW_PAIRS), .PLANES(PLANES), .BASE_TIME(BASE_TIME)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .address_b_o(addr), .clock_en_b_o(cen), .qb_i(qb),
    .panel_clk_o(pclk), .panel_latch_o(latch), .panel_oe_o(oe),
    .panel_row_addr_o(row_addr), .rgb1_o(rgb1), .rgb2_o(rgb2),
    .frame_start_o(fs)
  );

  always #5 clk = ~clk;

  // Frame buffer: registered read, one cycle latency.
  always @(posedge clk) if (cen) qb <= mem[addr];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Plane p shows bit p of the top PLANES bits of each 5-bit channel (green uses its top 5 bits).
  function automatic logic [2:0] px(input logic [15:0] w, input int plane);
    int k;
    k = 5 - PLANES + plane;
    return {w[11 + k], w[6 + k], w[k]};
  endfunction

  task automatic push_passes(input int count);
    for (int n = 0; n < count; n++) begin
      int plane;
      int row;
      plane = n % PLANES;
      row   = (n / PLANES) % ROW_PAIRS;
      for (int c = 0; c < COLUMNS; c++) begin
        int top;
        int bot;
        top = row * COLUMNS + c;
        bot = top + COLUMNS * ROW_PAIRS;
        exp_addr.push_back(11'(top));
        exp_addr.push_back(11'(bot));
        exp_pix.push_back({px(mem[top], plane), px(mem[bot], plane)});
      end
      exp_row.push_back(4'(row));
      exp_run.push_back(BASE_TIME << plane);
    end
  endtask

  int rises = 0, since_rise = 0, run = 0;
  logic prev_pclk = 1'b0, prev_latch = 1'b0, prev_oe = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      rises = 0; since_rise = 0; run = 0;
      prev_pclk = 1'b0; prev_latch = 1'b0; prev_oe = 1'b1;
    end else begin
      if (cen) begin
        chk("read_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) chk("read_addr", addr, exp_addr.pop_front());
      end
      if (pclk && !prev_pclk) begin
        rises++;
        since_rise = 0;
        chk("rise_expected", exp_pix.size() > 0, 1);
        if (exp_pix.size() > 0) chk("rgb_pair", {rgb1, rgb2}, exp_pix.pop_front());
      end else begin
        since_rise++;
      end
      if (latch) begin
        chk("latch_single", prev_latch, 0);
        if (!prev_latch) begin
          chk("rises_per_pass", rises, COLUMNS);
          chk("latch_gap", since_rise, 2);
          chk("row_expected", exp_row.size() > 0, 1);
          if (exp_row.size() > 0) chk("row_addr", row_addr, exp_row.pop_front());
          rises = 0;
        end
      end
      if (!oe) begin
        run++;
        chk("oe_blanked", {cen, pclk, latch}, 0);
      end else if (!prev_oe) begin
        chk("run_expected", exp_run.size() > 0, 1);
        if (exp_run.size() > 0) chk("oe_run", run, exp_run.pop_front());
        run = 0;
      end
      if (fs) fs_count++;
      prev_pclk  = pclk;
      prev_latch = latch;
      prev_oe    = oe;
    end
  end

  task automatic drive(input logic r, input logic e);
    @(negedge clk);
    #1 rst = r; enable = e;
  endtask

  task automatic wait_latches(input int n, input int budget);
    int cnt = 0;
    int t = 0;
    while (cnt < n && t < budget) begin
      @(negedge clk);
      t++;
      if (latch) cnt++;
    end
    chk("latch_wait", cnt, n);
  endtask

  task automatic wait_rises(input int n, input int budget);
    int cnt = 0;
    int t = 0;
    logic p = 1'b0;
    while (cnt < n && t < budget) begin
      @(negedge clk);
      t++;
      if (pclk && !p) cnt++;
      p = pclk;
    end
    chk("rise_wait", cnt, n);
  endtask

  task automatic check_reset_values();
    chk("rst_addr", addr, 0);
    chk("rst_cen", cen, 0);
    chk("rst_pclk", pclk, 0);
    chk("rst_latch", latch, 0);
    chk("rst_oe", oe, 1);
    chk("rst_row", row_addr, 0);
    chk("rst_rgb", {rgb1, rgb2}, 0);
    chk("rst_fs", fs, 0);
  endtask

  task automatic settle_idle(input int exp_fs);
    repeat (300) @(negedge clk);
    chk("idle_oe", oe, 1);
    chk("idle_cen", cen, 0);
    chk("left_reads", exp_addr.size(), 0);
    chk("left_pixels", exp_pix.size(), 0);
    chk("left_rows", exp_row.size(), 0);
    chk("left_runs", exp_run.size(), 0);
    chk("frame_starts", fs_count, exp_fs);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
  endtask

  initial begin
    fill_random();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    drive(1'b0, 1'b0);

    // Full frame plus one pass: rows 0..15, then back to row 0 with a second frame start.
    push_passes(ROW_PAIRS * PLANES + 1);
    drive(1'b0, 1'b1);
    @(negedge clk);
    chk("first_fs", fs, 1);
    chk("first_cen", cen, 1);
    chk("first_addr", addr, 0);
    wait_latches(ROW_PAIRS * PLANES + 1, 30000);
    #1 enable = 1'b0;
    settle_idle(2);

    // Directed pixels: a single white pixel, a blue bottom pixel, and an MSB-only pixel.
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[5]    = 16'hFFFF;
    mem[1029] = 16'h001F;
    mem[7]    = 16'h8410;
    push_passes(PLANES);
    drive(1'b0, 1'b1);
    wait_latches(PLANES, 3000);
    #1 enable = 1'b0;
    settle_idle(3);

    // Enable dropped mid-shift: the pass still completes, then no more reads.
    fill_random();
    push_passes(1);
    drive(1'b0, 1'b1);
    wait_rises(10, 1000);
    #1 enable = 1'b0;
    wait_latches(1, 1000);
    settle_idle(4);

    // Reset mid-shift, then restart from row 0, plane 0.
    push_passes(1);
    drive(1'b0, 1'b1);
    wait_rises(30, 1000);
    #1 rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    check_reset_values();
    exp_addr.delete();
    exp_pix.delete();
    exp_row.delete();
    exp_run.delete();
    drive(1'b0, 1'b0);
    push_passes(1);
    drive(1'b0, 1'b1);
    @(negedge clk);
    chk("restart_fs", fs, 1);
    chk("restart_addr", addr, 0);
    wait_latches(1, 1000);
    #1 enable = 1'b0;
    settle_idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
